// File: rtl/motor_spi_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : motor_spi_scheduler_if                                          |
// | Purpose  : Bundles the host register-file port, the SPI master handshake   |
// |            and the status outputs of motor_spi_scheduler.                  |
// | Modports : master - the scheduler side (drives go/dev_sel/datai, rd_data,  |
// |                     sweep_done, err_flags)                                 |
// |            slave  - the environment side (host + downstream SPI master)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface motor_spi_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DEV    = 7
);
  // Host side
  logic                  enable;
  logic                  tx_we;
  logic [2:0]            tx_addr;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [2:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  // SPI master handshake
  logic                  go;
  logic [2:0]            dev_sel;
  logic [DATA_WIDTH-1:0] datai;
  logic                  done;
  logic [DATA_WIDTH-1:0] datao;
  // Status
  logic                  sweep_done;
  logic [NUM_DEV-1:0]    err_flags;

  modport master (
    input  enable, tx_we, tx_addr, tx_data, rd_addr, done, datao,
    output rd_data, go, dev_sel, datai, sweep_done, err_flags
  );

  modport slave (
    output enable, tx_we, tx_addr, tx_data, rd_addr, done, datao,
    input  rd_data, go, dev_sel, datai, sweep_done, err_flags
  );
endinterface
`default_nettype wire

// File: rtl/motor_spi_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : motor_spi_scheduler                                             |
// | Purpose  : Round-robin sequencer in front of the motor-board SPI master.   |
// |            Walks devices 0..NUM_DEV-1 (drivers then ADCs), launches one    |
// |            transaction per device from a host-written tx register file and |
// |            captures the returned words into a rx register file. Sweeps     |
// |            repeat while enable is high, separated by a programmable gap.   |
// | Ports    : clk     - system clock                                          |
// |            resetb  - asynchronous active-low reset                         |
// |            bus     - motor_spi_scheduler_if.master (host tx/rd port, SPI   |
// |                      go/dev_sel/datai/done/datao, sweep_done, err_flags)   |
// | Options  : MOTOR_SPI_TIMEOUT_EN - adds a WAIT watchdog of TIMEOUT_CYCLES   |
// |            and per-device err_flags; otherwise err_flags is tied to 0.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module motor_spi_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_DEV        = 7,
  parameter int GAP_CYCLES     = 64
`ifdef MOTOR_SPI_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  resetb,
  motor_spi_scheduler_if.master bus
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [2:0]       LAST_DEV = 3'(NUM_DEV - 1);
  // GAP spans counts 0..GAP_CYCLES, so that together with LOAD and START the
  // next go lands GAP_CYCLES+3 cycles after the sweep_done pulse.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t                state_q,   state_d;
  logic [2:0]            idx_q,     idx_d;
  logic [2:0]            dev_sel_q, dev_sel_d;
  logic [DATA_WIDTH-1:0] datai_q,   datai_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q [NUM_DEV];
  logic [DATA_WIDTH-1:0] tx_d [NUM_DEV];
  logic [DATA_WIDTH-1:0] rx_q [NUM_DEV];
  logic [DATA_WIDTH-1:0] rx_d [NUM_DEV];
  logic                  sweep_done_w;

`ifdef MOTOR_SPI_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [NUM_DEV-1:0] err_q,      err_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dev_sel_d    = dev_sel_q;
    datai_d      = datai_q;
    gap_cnt_d    = gap_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    sweep_done_w = 1'b0;
`ifdef MOTOR_SPI_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
`endif

    // Host writes land in any state; datai only follows tx_reg at LOAD.
    if (bus.tx_we && (bus.tx_addr <= LAST_DEV)) begin
      tx_d[bus.tx_addr] = bus.tx_data;
    end

    case (state_q)
      S_IDLE: begin
        idx_d = 3'd0;
        if (bus.enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        datai_d   = tx_q[idx_q];
        dev_sel_d = idx_q;
        state_d   = S_START;
      end
      S_START: begin
`ifdef MOTOR_SPI_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done) begin
          rx_d[idx_q] = bus.datao;
`ifdef MOTOR_SPI_TIMEOUT_EN
          err_d[idx_q] = 1'b0;
`endif
          state_d = S_NEXT;
        end
`ifdef MOTOR_SPI_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          err_d[idx_q] = 1'b1;
          state_d      = S_NEXT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_NEXT: begin
        if (idx_q == LAST_DEV) begin
          sweep_done_w = 1'b1;
          idx_d        = 3'd0;
          gap_cnt_d    = '0;
          state_d      = S_GAP;
        end else if (!bus.enable) begin
          // Partial sweep is abandoned without a sweep_done pulse.
          idx_d   = 3'd0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = bus.enable ? S_LOAD : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      dev_sel_q  <= 3'd0;
      datai_q    <= '0;
      gap_cnt_q  <= '0;
      tx_q       <= '{default: '0};
      rx_q       <= '{default: '0};
`ifdef MOTOR_SPI_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dev_sel_q  <= dev_sel_d;
      datai_q    <= datai_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
`ifdef MOTOR_SPI_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.go         = (state_q == S_START);
  assign bus.dev_sel    = dev_sel_q;
  assign bus.datai      = datai_q;
  assign bus.sweep_done = sweep_done_w;
  assign bus.rd_data    = (bus.rd_addr <= LAST_DEV) ? rx_q[bus.rd_addr] : '0;
`ifdef MOTOR_SPI_TIMEOUT_EN
  assign bus.err_flags  = err_q;
`else
  assign bus.err_flags  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motor_spi_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_motor_spi_scheduler                                          |
// | Purpose  : Self-checking bench for motor_spi_scheduler. A single thread    |
// |            plays host and SPI master; expected values come from a small    |
// |            device-level model (tx/rx/err arrays, expected device order).   |
// | Options  : MOTOR_SPI_TIMEOUT_EN - also exercises the WAIT watchdog.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_motor_spi_scheduler;
  localparam int DW   = 16;
  localparam int NDEV = 7;
  localparam int GAP  = 10;
  localparam int TO   = 100;
  localparam int MAXW = GAP + 200;

  logic clk = 1'b0;
  logic resetb;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  motor_spi_scheduler_if #(.DATA_WIDTH(DW), .NUM_DEV(NDEV)) bus ();

  motor_spi_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_DEV    (NDEV),
    .GAP_CYCLES (GAP)
`ifdef MOTOR_SPI_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  // Reference model
  logic [DW-1:0]   tx_m [NDEV];
  logic [DW-1:0]   rx_m [NDEV];
  logic [NDEV-1:0] err_m;
  int exp_dev;
  int last_done_cyc;
  int exp_lat;
  bit lat_chk;
  bit rand_wr;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NDEV; i++) begin
      tx_m[i] = '0;
      rx_m[i] = '0;
    end
    err_m = '0;
  endtask

  // Fits inside one half clock period (8 x #1).
  task automatic check_rx_all();
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      #1;
      check("rx_read", 32'(bus.rd_data), (a < NDEV) ? 32'(rx_m[a]) : 32'd0);
    end
  endtask

  task automatic check_reset_state();
    check("rst_go",         32'(bus.go),         32'd0);
    check("rst_dev_sel",    32'(bus.dev_sel),    32'd0);
    check("rst_datai",      32'(bus.datai),      32'd0);
    check("rst_sweep_done", 32'(bus.sweep_done), 32'd0);
    check("rst_err_flags",  32'(bus.err_flags),  32'd0);
    check_rx_all();
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] v);
    @(negedge clk);
    bus.tx_we   = 1'b1;
    bus.tx_addr = 3'(a);
    bus.tx_data = v;
    if (a < NDEV) tx_m[a] = v;
    @(negedge clk);
    bus.tx_we = 1'b0;
  endtask

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (bus.go) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Serve one transaction as the SPI master.
  // mode: 0 normal, 1 write tx[3]=5678 during WAIT, 2 drop enable during WAIT,
  //       3 assert reset during WAIT, 4 withhold done (timeout), 5 poke done in GAP
  task automatic serve(input int lat, input logic [DW-1:0] rsp, input int mode);
    bit            ok;
    int            d;
    int            s;
    logic [DW-1:0] held;
    bit            stable;
    bit            extra;
    int            a;
    logic [DW-1:0] v;
    wait_go(ok);
    check("go_seen", 32'(ok), 32'd1);
    if (!ok) return;
    s = cyc;
    d = int'(bus.dev_sel);
    if (lat_chk) check("go_latency", 32'(s - last_done_cyc), 32'(exp_lat));
    lat_chk = 1'b1;
    check("dev_sel", 32'(bus.dev_sel), 32'(exp_dev));
    check("datai",   32'(bus.datai),   32'(tx_m[exp_dev]));
    held   = bus.datai;
    stable = 1'b1;
    extra  = 1'b0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      bus.tx_we = 1'b0;
      if (bus.go) extra = 1'b1;
      if (bus.datai !== held || bus.dev_sel !== 3'(d)) stable = 1'b0;
      if (mode == 1 && i == 1) begin
        bus.tx_we = 1'b1; bus.tx_addr = 3'd3; bus.tx_data = 16'h5678;
        tx_m[3] = 16'h5678;
      end else if (rand_wr && $urandom_range(0, 3) == 0) begin
        a = int'($urandom_range(0, 7));
        v = DW'($urandom);
        bus.tx_we = 1'b1; bus.tx_addr = 3'(a); bus.tx_data = v;
        if (a < NDEV) tx_m[a] = v;
      end
      if (mode == 2 && i == 2) bus.enable = 1'b0;
      if (mode == 3 && i == 3) begin
        bus.tx_we = 1'b0;
        resetb    = 1'b0;
        #1;
        clear_model();
        check_reset_state();
        return;
      end
    end
    @(negedge clk);
    bus.tx_we = 1'b0;
    if (mode == 4) begin
      check("err_before_timeout", 32'(bus.err_flags), 32'(err_m));
      @(negedge clk);
      err_m[d]      = 1'b1;
      last_done_cyc = s + lat;
      bus.rd_addr   = 3'(d);
      #1;
      check("rx_kept_on_timeout", 32'(bus.rd_data), 32'(rx_m[d]));
    end else begin
      bus.done    = 1'b1;
      bus.datao   = rsp;
      bus.rd_addr = 3'(d);
      last_done_cyc = cyc;
      #1;
      check("rx_capture_old", 32'(bus.rd_data), 32'(rx_m[d]));
      @(negedge clk);
      bus.done = 1'b0;
      rx_m[d]  = rsp;
      err_m[d] = 1'b0;
      check("rx_capture_new", 32'(bus.rd_data), 32'(rsp));
    end
    // Now in the NEXT cycle.
    check("datai_stable", 32'(stable), 32'd1);
    check("no_rego",      32'(extra),  32'd0);
    check("sweep_done",   32'(bus.sweep_done), (d == NDEV - 1) ? 32'd1 : 32'd0);
    check("err_flags",    32'(bus.err_flags),  32'(err_m));
    exp_lat = (d == NDEV - 1) ? GAP + 4 : 3;
    exp_dev = (d == NDEV - 1 || mode == 2) ? 0 : d + 1;
    if (mode == 2) lat_chk = 1'b0;
    if (mode == 5) begin
      repeat (3) @(negedge clk);
      bus.done  = 1'b1;
      bus.datao = 16'hDEAD;
      @(negedge clk);
      bus.done  = 1'b0;
    end
  endtask

  task automatic random_sweep();
    for (int k = 0; k < NDEV; k++) serve(int'($urandom_range(1, 30)), DW'($urandom), 0);
  endtask

  initial begin
    int n_go;
    resetb      = 1'b0;
    bus.enable  = 1'b0;
    bus.tx_we   = 1'b0;
    bus.tx_addr = '0;
    bus.tx_data = '0;
    bus.rd_addr = '0;
    bus.done    = 1'b0;
    bus.datao   = '0;
    clear_model();
    exp_dev = 0; last_done_cyc = 0; exp_lat = 3; lat_chk = 1'b0; rand_wr = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_state();
    @(negedge clk);
    resetb = 1'b1;

    host_write(3, 16'h1234);
    host_write(7, 16'hBEEF);   // out-of-range index must be dropped
    bus.enable = 1'b1;

    // Sweep 1: fixed responses, tx[3] rewritten mid-transaction, done poked in GAP.
    for (int k = 0; k < NDEV; k++)
      serve(20, DW'(16'hA000 + k), (k == 3) ? 1 : ((k == NDEV - 1) ? 5 : 0));
    check_rx_all();

    // Sweep 2: device 3 must now carry 0x5678.
    for (int k = 0; k < NDEV; k++) serve(20, DW'($urandom), 0);

    // Randomized sweeps with random latencies and host writes.
    rand_wr = 1'b1;
    repeat (2) random_sweep();
    check_rx_all();

    // Drop enable while device 2 is in flight.
    serve(int'($urandom_range(1, 30)), DW'($urandom), 0);
    serve(int'($urandom_range(1, 30)), DW'($urandom), 0);
    serve(20, DW'($urandom), 2);
    n_go = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.go) n_go++;
    end
    check("no_go_after_drop", 32'(n_go), 32'd0);
    check_rx_all();
    bus.enable = 1'b1;

    // Reset while device 4 is in flight, then a fresh sweep from device 0.
    for (int k = 0; k < 4; k++) serve(int'($urandom_range(1, 30)), DW'($urandom), 0);
    serve(20, DW'($urandom), 3);
    repeat (3) @(negedge clk);
    resetb  = 1'b1;
    exp_dev = 0;
    lat_chk = 1'b0;
    random_sweep();
    check_rx_all();

`ifdef MOTOR_SPI_TIMEOUT_EN
    // Device 5 never answers, then recovers on the following sweep.
    for (int k = 0; k < NDEV; k++)
      serve((k == 5) ? TO : 20, DW'($urandom), (k == 5) ? 4 : 0);
    check_rx_all();
    random_sweep();
    check_rx_all();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop so the bench never hangs.
  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
